// File: rtl/offset_field_stage.sv
// Decode-side stage: classifies fetched instructions, extracts the offset field
// for sign_extender, and buffers them in a 2-entry skid FIFO.
module offset_field_stage #(
  parameter int DATA_W     = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_pc,
  output logic [1:0]        out_class,
  output logic [DATA_W-1:0] ext_in,
  output logic [3:0]        msb_num,
  output logic              shift_first
);

  localparam logic [1:0] CLS_OTHER  = 2'd0;
  localparam logic [1:0] CLS_BL     = 2'd1;
  localparam logic [1:0] CLS_BRANCH = 2'd2;
  localparam logic [1:0] CLS_LDST   = 2'd3;
  localparam logic [1:0] DEPTH      = SKID_DEPTH[1:0];

  logic [DATA_W-1:0] inst_q  [SKID_DEPTH];
  logic [DATA_W-1:0] pc_q    [SKID_DEPTH];
  logic [DATA_W-1:0] ext_q   [SKID_DEPTH];
  logic [1:0]        cls_q   [SKID_DEPTH];
  logic [3:0]        msb_q   [SKID_DEPTH];
  logic              shift_q [SKID_DEPTH];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic [DATA_W-1:0] ext_d;
  logic [1:0]        cls_d;
  logic [3:0]        msb_d;
  logic              shift_d;
  logic              accept, pop;

  assign in_ready  = (count < DEPTH);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Classification happens on the incoming word and is stored with the entry.
  always_comb begin
    cls_d   = CLS_OTHER;
    ext_d   = '0;
    msb_d   = 4'd15;
    shift_d = 1'b0;
    if (in_inst[15]) begin
      cls_d = CLS_LDST;
      ext_d = {9'b0, in_inst[13:7]};
      msb_d = 4'd6;
    end else if (in_inst[15:13] == 3'b000) begin
      cls_d   = CLS_BL;
      ext_d   = {3'b0, in_inst[12:0]};
      msb_d   = 4'd13;
      shift_d = 1'b1;
    end else if (in_inst[15:13] == 3'b001) begin
      cls_d   = CLS_BRANCH;
      ext_d   = {6'b0, in_inst[9:0]};
      msb_d   = 4'd10;
      shift_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        inst_q[i]  <= '0;
        pc_q[i]    <= '0;
        ext_q[i]   <= '0;
        cls_q[i]   <= CLS_OTHER;
        msb_q[i]   <= 4'd0;
        shift_q[i] <= 1'b0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        inst_q[i]  <= '0;
        pc_q[i]    <= '0;
        ext_q[i]   <= '0;
        cls_q[i]   <= CLS_OTHER;
        msb_q[i]   <= 4'd0;
        shift_q[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        inst_q[wr_ptr]  <= in_inst;
        pc_q[wr_ptr]    <= in_pc;
        ext_q[wr_ptr]   <= ext_d;
        cls_q[wr_ptr]   <= cls_d;
        msb_q[wr_ptr]   <= msb_d;
        shift_q[wr_ptr] <= shift_d;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (accept && !pop)
        count <= count + 2'd1;
      else if (pop && !accept)
        count <= count - 2'd1;
    end
  end

  // Data outputs read as zero whenever the buffer holds nothing.
  assign out_inst    = out_valid ? inst_q[rd_ptr]  : '0;
  assign out_pc      = out_valid ? pc_q[rd_ptr]    : '0;
  assign out_class   = out_valid ? cls_q[rd_ptr]   : 2'd0;
  assign ext_in      = out_valid ? ext_q[rd_ptr]   : '0;
  assign msb_num     = out_valid ? msb_q[rd_ptr]   : 4'd0;
  assign shift_first = out_valid ? shift_q[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_offset_field_stage.sv
// Directed bench for offset_field_stage: classification, skid buffering,
// flush priority and asynchronous reset.
module tb_offset_field_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [1:0]  out_class;
  logic [15:0] ext_in;
  logic [3:0]  msb_num;
  logic        shift_first;

  int vectors     = 0;
  int miscompares = 0;

  offset_field_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_class(out_class), .ext_in(ext_in), .msb_num(msb_num), .shift_first(shift_first)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference sign_extender: optional left shift, then extend from bit msb.
  function automatic logic [15:0] extend(input logic [15:0] v, input logic [3:0] msb,
                                         input logic sh);
    logic [15:0] t;
    t = sh ? (v << 1) : v;
    for (int i = 0; i < 16; i++)
      if (i > int'(msb)) t[i] = t[msb];
    return t;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #23;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    vectors++;
    if ({out_inst, out_pc, out_class, ext_in, msb_num, shift_first} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: inst=%h pc=%h cls=%0d ext=%h msb=%0d sh=%b expected all 0",
               out_inst, out_pc, out_class, ext_in, msb_num, shift_first);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_classify();
    logic [15:0] vin  [4] = '{16'h1FFF, 16'h2200, 16'hA000, 16'h4000};
    logic [1:0]  vcls [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] vext [4] = '{16'h1FFF, 16'h0200, 16'h0040, 16'h0000};
    logic [3:0]  vmsb [4] = '{4'd13, 4'd10, 4'd6, 4'd15};
    logic        vsh  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] vsx  [4] = '{16'hFFFE, 16'hFC00, 16'hFFC0, 16'h0000};
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = vin[0];
    in_pc     = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        in_inst = vin[i+1];
        in_pc   = 16'h0100 + 16'(2*(i+1));
      end else begin
        in_valid = 1'b0;
      end
      vectors++;
      if (out_valid !== 1'b1 || out_inst !== vin[i] || out_pc !== 16'h0100 + 16'(2*i)) begin
        miscompares++;
        $display("[TB] FAIL classify_head[%0d]: valid=%b inst=%h pc=%h expected 1 %h %h",
                 i, out_valid, out_inst, out_pc, vin[i], 16'h0100 + 16'(2*i));
      end
      vectors++;
      if (out_class !== vcls[i] || ext_in !== vext[i] || msb_num !== vmsb[i] || shift_first !== vsh[i]) begin
        miscompares++;
        $display("[TB] FAIL classify_fields[%0d]: cls=%0d ext=%h msb=%0d sh=%b expected %0d %h %0d %b",
                 i, out_class, ext_in, msb_num, shift_first, vcls[i], vext[i], vmsb[i], vsh[i]);
      end
      if (i < 3) begin
        vectors++;
        if (extend(ext_in, msb_num, shift_first) !== vsx[i]) begin
          miscompares++;
          $display("[TB] FAIL extender_result[%0d]: got %h expected %h",
                   i, extend(ext_in, msb_num, shift_first), vsx[i]);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_inst !== 16'h0 || ext_in !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL classify_drain: valid=%b inst=%h ext=%h expected 0 0000 0000", out_valid, out_inst, ext_in);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_inst = 16'h0123; in_pc = 16'h0200;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_inst !== 16'h0123) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: valid=%b ready=%b inst=%h expected 1 1 0123", out_valid, in_ready, out_inst);
    end
    in_inst = 16'h2345; in_pc = 16'h0202;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_inst !== 16'h0123 || out_class !== 2'd1 || ext_in !== 16'h0123) begin
      miscompares++;
      $display("[TB] FAIL b2b_full: ready=%b inst=%h cls=%0d ext=%h expected 0 0123 1 0123",
               in_ready, out_inst, out_class, ext_in);
    end
    in_inst = 16'h8F80; in_pc = 16'h0204;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_inst !== 16'h0123 || out_pc !== 16'h0200) begin
      miscompares++;
      $display("[TB] FAIL b2b_stall_hold: ready=%b inst=%h pc=%h expected 0 0123 0200", in_ready, out_inst, out_pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_inst !== 16'h2345 || out_class !== 2'd2 || ext_in !== 16'h0345 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: inst=%h cls=%0d ext=%h ready=%b expected 2345 2 0345 1",
               out_inst, out_class, ext_in, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_inst !== 16'h8F80 || out_class !== 2'd3 || ext_in !== 16'h001F
        || msb_num !== 4'd6 || out_pc !== 16'h0204) begin
      miscompares++;
      $display("[TB] FAIL b2b_third: valid=%b inst=%h cls=%0d ext=%h msb=%0d pc=%h expected 1 8F80 3 001F 6 0204",
               out_valid, out_inst, out_class, ext_in, msb_num, out_pc);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_no_dup: valid=%b inst=%h expected valid 0", out_valid, out_inst);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 16'h0AAA; in_pc = 16'h0300;
    @(negedge clk);
    in_inst = 16'h2BBB; in_pc = 16'h0302;
    @(negedge clk);
    in_inst = 16'h0CCC; in_pc = 16'h0304;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_full_state: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    vectors++;
    if ({out_inst, out_pc, out_class, ext_in, msb_num, shift_first} !== '0) begin
      miscompares++;
      $display("[TB] FAIL flush_full_data: inst=%h ext=%h msb=%0d expected zeros", out_inst, ext_in, msb_num);
    end
    // One entry present and a word offered that would otherwise be accepted.
    in_valid = 1'b1; in_inst = 16'h0DDD; in_pc = 16'h0306;
    @(negedge clk);
    in_inst = 16'h2EEE; in_pc = 16'h0308;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_inst = 16'h4321; in_pc = 16'h030A;
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || out_inst !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL flush_priority: valid=%b inst=%h expected 0 0000", out_valid, out_inst);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_inst !== 16'h4321 || out_class !== 2'd0 || msb_num !== 4'd15 || ext_in !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL flush_recover: valid=%b inst=%h cls=%0d msb=%0d ext=%h expected 1 4321 0 15 0000",
               out_valid, out_inst, out_class, msb_num, ext_in);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 16'h1234; in_pc = 16'h0400;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_inst !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL areset_pre: valid=%b inst=%h expected 1 1234", out_valid, out_inst);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 16'h0 || ext_in !== 16'h0 || msb_num !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate: valid=%b ready=%b inst=%h ext=%h msb=%0d expected 0 1 0000 0000 0",
               out_valid, in_ready, out_inst, ext_in, msb_num);
    end
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; in_inst = 16'h3001; in_pc = 16'h0500;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_inst !== 16'h3001 || out_pc !== 16'h0500 || out_class !== 2'd2
        || ext_in !== 16'h0001 || shift_first !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_resume: valid=%b inst=%h pc=%h cls=%0d ext=%h sh=%b expected 1 3001 0500 2 0001 1",
               out_valid, out_inst, out_pc, out_class, ext_in, shift_first);
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
